// File: rtl/pipe_trace_buffer.sv
// Pipeline trace capture: round-robin stage arbiter, timestamped ring buffer, trigger FSM.
// Optional TRACE_WRAP_EN: a full buffer overwrites its oldest entry instead of discarding.
module pipe_trace_buffer #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int CYC_W    = 32,
    parameter int POST_CNT = 8,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     trig,
    input  logic                     clr,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [CH_W-1:0]          rd_ch,
    output logic [CYC_W-1:0]         rd_cycle,
    output logic [PTR_W:0]           count,
    output logic [1:0]               state,
    output logic [CYC_W-1:0]         cycle_count,
    output logic [15:0]              drop_count,
    output logic                     overflow
);

    localparam int ENT_W = CH_W + CYC_W + DATA_W;
    localparam int PC_W  = $clog2(POST_CNT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_FROZEN  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [CYC_W-1:0]  cyc_q;
    logic [15:0]       drop_q, drop_d;
    logic              ovf_q, ovf_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [PC_W-1:0]   post_q, post_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];

    logic              gnt_vld;
    logic [CH_W-1:0]   gnt;
    logic [16:0]       nval;
    int                arb_idx;
    logic              cap_en, pop, full, wr_att, store, ovr, wrap, wr_en;
    logic [16:0]       drop_inc, drop_sum;
    logic [ENT_W-1:0]  head;

    // Search starts at rr_q and walks upward modulo NUM_CH.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        nval    = '0;
        arb_idx = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            arb_idx = (int'(rr_q) + k) % NUM_CH;
            if (!gnt_vld && ch_valid[arb_idx]) begin
                gnt_vld = 1'b1;
                gnt     = CH_W'(arb_idx);
            end
            nval = nval + 17'(ch_valid[k]);
        end
    end

    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid && rd_ready;
    assign full     = (count_q == (PTR_W + 1)'(DEPTH));
    assign cap_en   = (state_q == S_CAPTURE) || (state_q == S_POST) ||
                      ((state_q == S_IDLE) && trig);
    assign wr_att   = cap_en && gnt_vld && !clr;
    assign store    = wr_att && (!full || pop);
    assign ovr      = wr_att && full && !pop;
`ifdef TRACE_WRAP_EN
    assign wrap     = ovr;
    assign drop_inc = (cap_en && gnt_vld) ? nval - 17'd1 : 17'd0;
`else
    assign wrap     = 1'b0;
    assign drop_inc = (cap_en && gnt_vld) ? nval - 17'd1 + 17'(ovr) : 17'd0;
`endif
    assign wr_en    = store || wrap;
    assign drop_sum = {1'b0, drop_q} + drop_inc;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        rr_d     = rr_q;
        post_d   = post_q;
        if (clr) begin
            state_d  = S_IDLE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            drop_d   = '0;
            ovf_d    = 1'b0;
            post_d   = '0;
        end else begin
            drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop || wrap) rd_ptr_d = rd_ptr_q + 1'b1;
            if (store && !pop) count_d = count_q + 1'b1;
            else if (!store && pop) count_d = count_q - 1'b1;
            if (ovr) ovf_d = 1'b1;
            if (cap_en && gnt_vld)
                rr_d = (int'(gnt) == NUM_CH - 1) ? '0 : gnt + 1'b1;
            case (state_q)
                S_IDLE: if (trig) state_d = S_CAPTURE;
                S_CAPTURE: begin
                    if (trig) begin
                        state_d = S_POST;
                        post_d  = '0;
                    end
                end
                S_POST: begin
                    if (wr_en) begin
                        post_d = post_q + 1'b1;
                        if (post_q + 1'b1 == PC_W'(POST_CNT)) state_d = S_FROZEN;
                    end
                end
                default: state_d = S_FROZEN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cyc_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            rr_q     <= '0;
            post_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            cyc_q    <= cyc_q + 1'b1;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            rr_q     <= rr_d;
            post_q   <= post_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= {gnt, cyc_q, ch_data[int'(gnt)*DATA_W +: DATA_W]};
    end

    // Head fields are gated so every output reads zero while empty or in reset.
    assign head        = mem_q[rd_ptr_q];
    assign rd_data     = rd_valid ? head[DATA_W-1:0] : '0;
    assign rd_cycle    = rd_valid ? head[DATA_W +: CYC_W] : '0;
    assign rd_ch       = rd_valid ? head[DATA_W+CYC_W +: CH_W] : '0;
    assign count       = count_q;
    assign state       = state_q;
    assign cycle_count = cyc_q;
    assign drop_count  = drop_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Bench for pipe_trace_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_trace_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   ch_valid = '0;
    logic [127:0] ch_data = '0;
    logic         trig = 1'b0;
    logic         clr = 1'b0;
    logic         rd_ready = 1'b0;
    logic         rd_valid;
    logic [31:0]  rd_data;
    logic [1:0]   rd_ch;
    logic [31:0]  rd_cycle;
    logic [4:0]   count;
    logic [1:0]   state;
    logic [31:0]  cycle_count;
    logic [15:0]  drop_count;
    logic         overflow;

    pipe_trace_buffer dut (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data),
        .trig(trig), .clr(clr), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_ch(rd_ch), .rd_cycle(rd_cycle), .count(count),
        .state(state), .cycle_count(cycle_count), .drop_count(drop_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: entries in a queue, plain integer bookkeeping.
    typedef struct { logic [31:0] data; int ch; logic [31:0] cyc; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_cyc;
    int          m_state, m_rr, m_post, m_drop;
    bit          m_ovf;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_cyc = 0; m_state = 0; m_rr = 0; m_post = 0; m_drop = 0; m_ovf = 0;
        end else begin
            logic [31:0] now;
            bit cap, pop, written;
            int g, nv;
            ent_t e;
            now = m_cyc;
            m_cyc = m_cyc + 1;
            if (clr) begin
                mq.delete();
                m_state = 0; m_post = 0; m_drop = 0; m_ovf = 0;
            end else begin
                pop = (mq.size() != 0) && rd_ready;
                cap = (m_state == 1) || (m_state == 2) || (m_state == 0 && trig);
                g = -1; nv = 0; written = 0;
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && ch_valid[(m_rr + k) % 4]) g = (m_rr + k) % 4;
                    nv += int'(ch_valid[k]);
                end
                if (pop) void'(mq.pop_front());
                if (cap && g >= 0) begin
                    m_drop += nv - 1;
                    m_rr = (g + 1) % 4;
                    e.data = ch_data[g*32 +: 32]; e.ch = g; e.cyc = now;
                    if (mq.size() < 16) begin
                        mq.push_back(e); written = 1;
                    end else begin
                        m_ovf = 1;
`ifdef TRACE_WRAP_EN
                        void'(mq.pop_front()); mq.push_back(e); written = 1;
`else
                        m_drop += 1;
`endif
                    end
                end
                if (m_drop > 65535) m_drop = 65535;
                case (m_state)
                    0: if (trig) m_state = 1;
                    1: if (trig) begin m_state = 2; m_post = 0; end
                    2: if (written) begin
                        m_post++;
                        if (m_post == 8) m_state = 3;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("m_valid", rd_valid, mq.size() != 0);
            chk("m_count", count, mq.size());
            chk("m_state", state, m_state);
            chk("m_cycle", cycle_count, m_cyc);
            chk("m_drop", drop_count, m_drop);
            chk("m_ovf", overflow, m_ovf);
            if (mq.size() != 0) begin
                chk("m_rd_data", rd_data, mq[0].data);
                chk("m_rd_ch", rd_ch, mq[0].ch);
                chk("m_rd_cycle", rd_cycle, mq[0].cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] base);
        ch_valid = v;
        for (int i = 0; i < 4; i++) ch_data[i*32 +: 32] = base + i;
    endtask

    localparam logic [31:0] H0 =
`ifdef TRACE_WRAP_EN
        32'hD03;
`else
        32'hD00;
`endif

    initial begin
        int guard;
        logic [31:0] last;
        #22;
        rst = 1'b1;
        chk("reset_state", state, 0);
        chk("reset_count", count, 0);

        // Scenario 1: trig at cycle 3, five ch0 events.
        guard = 0;
        while (cycle_count != 3 && guard < 20) begin step(); guard++; end
        chk("wait_cycle3", cycle_count, 3);
        trig = 1'b1;
        for (int n = 0; n < 5; n++) begin
            ch_valid = 4'b0001;
            ch_data = '0;
            ch_data[31:0] = 32'hA0 + n;
            step();
            trig = 1'b0;
        end
        ch_valid = '0;
        chk("s1_count", count, 5);
        rd_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            chk("s1_pop_data", rd_data, 32'hA0 + n);
            chk("s1_pop_ch", rd_ch, 0);
            chk("s1_pop_cycle", rd_cycle, 3 + n);
            step();
        end
        rd_ready = 1'b0;
        chk("s1_empty", rd_valid, 0);

        // Scenario 2: round-robin from rr_ptr=0 (last grant was ch3).
        clr = 1'b1; step(); clr = 1'b0;
        trig = 1'b1; drive(4'b1000, 32'hC0); step(); trig = 1'b0;
        drive(4'b1111, 32'hC0);
        repeat (4) step();
        ch_valid = '0;
        chk("s2_drop", drop_count, 12);
        chk("s2_count", count, 5);
        rd_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            chk("s2_rr_ch", rd_ch, (n + 3) % 4);
            step();
        end
        rd_ready = 1'b0;

        // Scenario 3: second trig, eight post entries, freeze, clr.
        trig = 1'b1; drive(4'b0001, 32'hF00); step(); trig = 1'b0;
        for (int n = 1; n < 13; n++) begin drive(4'b0001, 32'hF00 + 32'(n)); step(); end
        chk("s3_count", count, 9);
        chk("s3_state", state, 3);
        trig = 1'b1; repeat (2) step(); trig = 1'b0;
        ch_valid = '0;
        chk("s3_frozen_count", count, 9);
        chk("s3_frozen_drop", drop_count, 12);
        clr = 1'b1; step(); clr = 1'b0;
        chk("s3_clr_state", state, 0);
        chk("s3_clr_count", count, 0);
        chk("s3_clr_ovf", overflow, 0);

        // Scenario 4: 19 writes into a 16-entry buffer, no reads.
        trig = 1'b1;
        for (int n = 0; n < 19; n++) begin
            ch_valid = 4'b0001;
            ch_data[31:0] = 32'hD00 + n;
            step();
            trig = 1'b0;
        end
        ch_valid = '0;
        chk("s4_count", count, 16);
        chk("s4_ovf", overflow, 1);
        chk("s4_head", rd_data, H0);
`ifdef TRACE_WRAP_EN
        chk("s4_drop", drop_count, 0);
`else
        chk("s4_drop", drop_count, 3);
`endif

        // Scenario 5: full buffer, write and pop together.
        ch_valid = 4'b0001; ch_data[31:0] = 32'hE0; rd_ready = 1'b1;
        chk("s5_popped", rd_data, H0);
        step();
        ch_valid = '0;
        chk("s5_count", count, 16);
        chk("s5_new_head", rd_data, H0 + 1);
        last = '0;
        for (int n = 0; n < 16; n++) begin last = rd_data; step(); end
        rd_ready = 1'b0;
        chk("s5_last", last, 32'hE0);
        chk("s5_drained", count, 0);

        // Scenario 6: asynchronous reset between edges mid-capture.
        clr = 1'b1; step(); clr = 1'b0;
        trig = 1'b1; drive(4'b0011, 32'h60); step(); trig = 1'b0;
        repeat (2) step();
        #1;
        rst = 1'b0;
        #1;
        chk("s6_state", state, 0);
        chk("s6_valid", rd_valid, 0);
        chk("s6_count", count, 0);
        chk("s6_cycle", cycle_count, 0);
        chk("s6_data", rd_data, 0);
        ch_valid = '0;
        #4;
        rst = 1'b1;
        repeat (3) step();
        chk("s6_cycle_run", cycle_count, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
